ps2_host_tx: RTL
================

// Module: ps2_host_tx
// PURPOSE
//  PS/2 host-to-device transmitter. Sends one command byte to the keyboard, e.g. 0xED set-LEDs or 0xFF reset.
//  Sits beside the PS/2 receive module on the same SCL/SDA pins.
//  Pads are open-drain: the block only drives low or releases.
//  Top level builds pad = drive_low ? 1'b0 : 1'bz.
//  tx_busy gates the receiver so it ignores the host frame.
// PARAMETERS
//  INHIBIT_CYCLES  5000    clk cycles SCL is held low before start (100 us @ 50 MHz)
//  TIMEOUT_CYCLES  750000  watchdog limit, used only with PS2_TX_TIMEOUT_EN (15 ms @ 50 MHz)
// PORTS
//  clk            in   1  system clock, 50 MHz
//  rst            in   1  asynchronous reset, active-low
//  SCL            in   1  PS/2 clock pad, sampled
//  SDA            in   1  PS/2 data pad, sampled
//  tx_data        in   8  byte to send; latched on an accepted tx_start
//  tx_start       in   1  1-cycle request; ignored while tx_busy=1
//  tx_busy        out  1  high from the accepted start until the cycle tx_done pulses
//  tx_done        out  1  1-cycle pulse when the frame ends (ack, nack or timeout)
//  tx_ack_err     out  1  valid with tx_done: 1 = device did not ACK; held until next start
//  tx_timeout     out  1  valid with tx_done: 1 = watchdog expired; held until next start
//  SCL_drive_low  out  1  1 = pull SCL low
//  SDA_drive_low  out  1  1 = pull SDA low
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE, all outputs 0, pads released immediately, even mid-frame.
//  SCL and SDA each pass through a 2-FF synchronizer.
//  SCL falling edge = previous synchronized sample 1, current 0; detected 2-3 clk after the pad edge.
//  Frame shift register = {stop=1, parity, data[7:0]}, sent LSB first.
//  parity = ~^tx_data (odd parity).
//  States and transitions:
//   IDLE     tx_start & !tx_busy -> latch data, clear err flags, tx_busy=1, SCL_drive_low=1, counter=0 -> INHIBIT
//   INHIBIT  count INHIBIT_CYCLES clk -> SDA_drive_low=1 (start bit) -> REQ
//   REQ      one clk later SCL_drive_low=0; fall_cnt=0 -> SEND
//   SEND     on SCL fall #1..#9 drive d0..d7 then parity (SDA_drive_low = ~bit)
//            on fall #10 release SDA (stop bit) -> ACK
//   ACK      on fall #11 sample synchronized SDA: 0 -> ack ok, 1 -> tx_ack_err=1 -> WAIT_IDLE
//   WAIT_IDLE  wait until synced SCL=1 and SDA=1 for 1 clk -> tx_done=1, tx_busy=0 -> IDLE
//  Latency, start to first device clock: INHIBIT_CYCLES+2 clk plus the device response time.
//  fall_cnt is 4 bits and saturates; extra falls after #11 are ignored.
//  tx_start during tx_busy: dropped and not queued.
//  tx_start in the same cycle as tx_done: dropped; it is accepted one cycle later.
//  Device pulls SCL low during INHIBIT or REQ: no effect; the host already owns the line.
// CONFIGURATION
//  PS2_TX_TIMEOUT_EN defined:
//   - Watchdog counts clk from REQ entry; it does not reset on SCL edges.
//   - At TIMEOUT_CYCLES it releases both pads, sets tx_timeout=1 and tx_ack_err=1, pulses tx_done, -> IDLE.
//  PS2_TX_TIMEOUT_EN undefined:
//   - No watchdog; the block waits for the device indefinitely.
//   - tx_timeout is tied to 0.
// TESTING
//  - tx_data=0xED, device model ACKs -> SDA at falls 1..9 = 1,0,1,1,0,1,1,1,1; fall 10 released; tx_done=1, tx_ack_err=0.
//  - tx_data=0x01 -> parity bit 0; tx_data=0xFF -> parity bit 1; both ACKed; tx_busy low after tx_done.
//  - Inhibit timing: SCL_drive_low high for 5000 clk; SDA_drive_low rises on the last inhibit clk; SCL released 1 clk later.
//  - Device leaves SDA high at fall 11 -> tx_done with tx_ack_err=1, then bus idle, next start accepted.
//  - tx_start pulsed again mid-frame with 0x55 -> ignored; the frame on the wire stays 0xED.
//  - rst=0 at fall 5 -> both drive_low 0 in the same cycle, tx_busy=0.
//  - Macro on, device never clocks -> tx_timeout=1 and tx_done 750000 clk after REQ, pads released.

Source files
------------

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter driving open-drain SCL/SDA pads.
// Define PS2_TX_TIMEOUT_EN to enable the frame watchdog (TIMEOUT_CYCLES from REQ entry).
`default_nettype none
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       SCL,
  input  logic       SDA,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_ack_err,
  output logic       tx_timeout,
  output logic       SCL_drive_low,
  output logic       SDA_drive_low
);
  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    REQ       = 3'd2,
    SEND      = 3'd3,
    ACK       = 3'd4,
    WAIT_IDLE = 3'd5
  } state_t;

  state_t           state_q;
  logic [1:0]       scl_sync_q;
  logic [1:0]       sda_sync_q;
  logic             scl_prev_q;
  logic [INH_W-1:0] inh_cnt_q;
  logic [9:0]       shift_q;
  logic [3:0]       fall_cnt_q;
  logic             scl_s;
  logic             sda_s;
  logic             scl_fall;

`ifdef PS2_TX_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_q;
`else
  assign tx_timeout = 1'b0;
`endif

  assign scl_s    = scl_sync_q[1];
  assign sda_s    = sda_sync_q[1];
  assign scl_fall = scl_prev_q & ~scl_s;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      // Synchronizers reset to the idle-bus level so no false edge follows reset
      scl_sync_q    <= 2'b11;
      sda_sync_q    <= 2'b11;
      scl_prev_q    <= 1'b1;
      inh_cnt_q     <= '0;
      shift_q       <= '0;
      fall_cnt_q    <= '0;
      tx_busy       <= 1'b0;
      tx_done       <= 1'b0;
      tx_ack_err    <= 1'b0;
      SCL_drive_low <= 1'b0;
      SDA_drive_low <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
      wd_q          <= '0;
      tx_timeout    <= 1'b0;
`endif
    end else begin
      scl_sync_q <= {scl_sync_q[0], SCL};
      sda_sync_q <= {sda_sync_q[0], SDA};
      scl_prev_q <= scl_s;
      tx_done    <= 1'b0;

      case (state_q)
        IDLE: begin
          // A start coinciding with the done pulse is dropped on purpose
          if (tx_start && !tx_done) begin
            shift_q       <= {1'b1, ~^tx_data, tx_data};
            tx_ack_err    <= 1'b0;
            tx_busy       <= 1'b1;
            SCL_drive_low <= 1'b1;
            inh_cnt_q     <= '0;
            state_q       <= INHIBIT;
`ifdef PS2_TX_TIMEOUT_EN
            tx_timeout    <= 1'b0;
`endif
          end
        end
        INHIBIT: begin
          if (inh_cnt_q == INH_W'(INHIBIT_CYCLES - 2)) begin
            SDA_drive_low <= 1'b1;
            state_q       <= REQ;
`ifdef PS2_TX_TIMEOUT_EN
            wd_q          <= '0;
`endif
          end else begin
            inh_cnt_q <= inh_cnt_q + 1'b1;
          end
        end
        REQ: begin
          SCL_drive_low <= 1'b0;
          fall_cnt_q    <= '0;
          state_q       <= SEND;
        end
        SEND: begin
          // Falls 1..10 put d0..d7, parity, then the stop bit (release) on SDA
          if (scl_fall) begin
            SDA_drive_low <= ~shift_q[0];
            shift_q       <= {1'b0, shift_q[9:1]};
            fall_cnt_q    <= fall_cnt_q + 1'b1;
            if (fall_cnt_q == 4'd9) state_q <= ACK;
          end
        end
        ACK: begin
          if (scl_fall) begin
            tx_ack_err <= sda_s;
            if (fall_cnt_q != 4'hF) fall_cnt_q <= fall_cnt_q + 1'b1;
            state_q <= WAIT_IDLE;
          end
        end
        WAIT_IDLE: begin
          if (scl_s && sda_s) begin
            tx_done <= 1'b1;
            tx_busy <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase

`ifdef PS2_TX_TIMEOUT_EN
      // Watchdog overrides whatever the frame FSM decided this cycle
      if (state_q == REQ || state_q == SEND || state_q == ACK || state_q == WAIT_IDLE) begin
        if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
          SCL_drive_low <= 1'b0;
          SDA_drive_low <= 1'b0;
          tx_timeout    <= 1'b1;
          tx_ack_err    <= 1'b1;
          tx_done       <= 1'b1;
          tx_busy       <= 1'b0;
          state_q       <= IDLE;
        end else begin
          wd_q <= wd_q + 1'b1;
        end
      end
`endif
    end
  end
endmodule
`default_nettype wire
